// File: rtl/flocra_pkg.sv
// Shared definitions for the flofifo read-side drain engine.
package flocra_pkg;

  localparam int unsigned SKID_DEPTH = 4;
  localparam int unsigned SKID_PTR_W = 2;
  localparam int unsigned SKID_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/flofifo_skid4.sv
// Four-entry circular buffer holding words popped from the flofifo until the stream takes them.
module flofifo_skid4
  import flocra_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [SKID_CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0]      mem_q [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr_q;
  logic [SKID_PTR_W-1:0] rd_ptr_q;
  logic [SKID_CNT_W-1:0] cnt_q;
  logic [SKID_CNT_W-1:0] cnt_d;

  // Occupancy next-state: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + SKID_CNT_W'(1);
      2'b01:   cnt_d = cnt_q - SKID_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers and count; pointers wrap naturally at the buffer depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + SKID_PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + SKID_PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/flofifo_drain.sv
// Read-side engine: pops a flofifo into a skid buffer and emits AXI-Stream packets
// closed by a programmable burst length or by an explicit flush.
module flofifo_drain
  import flocra_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LENGTH = 32,
  parameter int unsigned BLEN_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          fifo_data_i,
  input  logic                      fifo_valid_i,
  input  logic                      fifo_empty_i,
  input  logic [$clog2(LENGTH)-1:0] fifo_locs_i,
  output logic                      fifo_read_o,
  output logic [WIDTH-1:0]          m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  input  logic [BLEN_W-1:0]         burst_len_i,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic [BLEN_W-1:0]         words_sent_o
);

  localparam int unsigned LOCS_W = $clog2(LENGTH);

  drain_state_e          state_q;
  logic                  rd_pend_q;
  logic                  hold_last_q;
  logic [BLEN_W-1:0]     beat_cnt_q;
  logic [BLEN_W-1:0]     beat_cnt_d;
  logic [BLEN_W-1:0]     burst_len_q;
  logic [BLEN_W-1:0]     burst_len_d;

  logic [WIDTH-1:0]      head_c;
  logic [SKID_CNT_W-1:0] buf_cnt_c;
  logic [SKID_CNT_W-1:0] credit_c;
  logic [BLEN_W-1:0]     blen_eff_c;
  logic                  burst_hit_c;
  logic                  flush_close_c;
  logic                  head_is_last_c;
  logic                  push_c;
  logic                  xfer_c;
  logic                  flush_done_c;

  flofifo_skid4 #(.WIDTH(WIDTH)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_c),
    .push_data_i (fifo_data_i),
    .pop_i       (xfer_c),
    .head_o      (head_c),
    .cnt_o       (buf_cnt_c)
  );

  // Credit covers words already buffered plus the one still in flight from the FIFO.
  assign credit_c    = buf_cnt_c + SKID_CNT_W'(rd_pend_q);
  assign fifo_read_o = !rst && !fifo_empty_i && (credit_c < SKID_CNT_W'(SKID_DEPTH))
                       && !(rd_pend_q && (fifo_locs_i < LOCS_W'(2)));
  // Only data answering our own pop enters the buffer.
  assign push_c      = fifo_valid_i && rd_pend_q;

  // The first beat of a packet uses the live burst length; later beats the latched copy.
  assign blen_eff_c     = (beat_cnt_q == '0) ? burst_len_i : burst_len_q;
  assign burst_hit_c    = (blen_eff_c != '0) && (beat_cnt_q == blen_eff_c - BLEN_W'(1));
  assign flush_close_c  = (state_q == ST_FLUSH) && fifo_empty_i && !rd_pend_q
                          && (buf_cnt_c == SKID_CNT_W'(1));
  // hold_last_q pins tlast once offered so a stalled last beat cannot lose it.
  assign head_is_last_c = hold_last_q || burst_hit_c || flush_close_c;

  // Hold back the final buffered word until it is known to be the packet's last.
  assign m_axis_tvalid = (buf_cnt_c >= SKID_CNT_W'(2))
                         || ((buf_cnt_c != '0) && head_is_last_c);
  assign m_axis_tlast  = m_axis_tvalid && head_is_last_c;
  assign m_axis_tdata  = m_axis_tvalid ? head_c : '0;
  assign xfer_c        = m_axis_tvalid && m_axis_tready;

  assign flush_done_c  = fifo_empty_i && !rd_pend_q && (buf_cnt_c == '0) && (beat_cnt_q == '0);

  assign busy_o       = (state_q != ST_IDLE);
  assign words_sent_o = beat_cnt_q;

  // Beat counter and burst-length latch next-state.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    burst_len_d = burst_len_q;
    if (xfer_c) begin
      beat_cnt_d = m_axis_tlast ? '0 : beat_cnt_q + BLEN_W'(1);
      if (beat_cnt_q == '0) burst_len_d = burst_len_i;
    end
  end

  // Packet FSM plus pending-read, last-hold and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_pend_q   <= 1'b0;
      hold_last_q <= 1'b0;
      beat_cnt_q  <= '0;
      burst_len_q <= '0;
    end else begin
      rd_pend_q   <= fifo_read_o;
      hold_last_q <= m_axis_tlast && !m_axis_tready;
      beat_cnt_q  <= beat_cnt_d;
      burst_len_q <= burst_len_d;
      case (state_q)
        ST_IDLE: begin
          if (flush_i)                      state_q <= ST_FLUSH;
          else if (xfer_c && !m_axis_tlast) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (flush_i)                      state_q <= ST_FLUSH;
          else if (xfer_c && m_axis_tlast)  state_q <= ST_IDLE;
        end
        ST_FLUSH: begin
          if ((xfer_c && m_axis_tlast) || flush_done_c) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flofifo_drain.sv
// Directed bench: behavioural flofifo feeding flofifo_drain, stream beats collected and checked.
module tb_flofifo_drain;

  logic        clk;
  logic        rst;
  logic [31:0] f_data;
  logic        f_valid;
  logic        f_empty;
  logic [4:0]  f_locs;
  logic        f_read;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [15:0] burst_len;
  logic        flush;
  logic        busy;
  logic [15:0] words_sent;

  logic        wr_en;
  logic [31:0] wr_data;

  int checks;
  int errors;

  flofifo_drain #(.WIDTH(32), .LENGTH(32), .BLEN_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_data_i   (f_data),
    .fifo_valid_i  (f_valid),
    .fifo_empty_i  (f_empty),
    .fifo_locs_i   (f_locs),
    .fifo_read_o   (f_read),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .burst_len_i   (burst_len),
    .flush_i       (flush),
    .busy_o        (busy),
    .words_sent_o  (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural flofifo: registered data, valid one cycle after read, occupancy count.
  logic [31:0] fmem [32];
  logic [4:0]  f_wptr;
  logic [4:0]  f_rptr;
  int          f_cnt;
  logic        f_rd_ok;
  logic        f_wr_ok;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f_wptr  <= '0;
      f_rptr  <= '0;
      f_cnt   <= 0;
      f_valid <= 1'b0;
      f_data  <= '0;
    end else begin
      f_rd_ok = f_read && (f_cnt > 0);
      f_wr_ok = wr_en && (f_cnt < 32);
      if (f_wr_ok) begin
        fmem[f_wptr] <= wr_data;
        f_wptr <= f_wptr + 5'd1;
      end
      if (f_rd_ok) begin
        f_data <= fmem[f_rptr];
        f_rptr <= f_rptr + 5'd1;
      end
      f_valid <= f_rd_ok;
      f_cnt   <= f_cnt + (f_wr_ok ? 1 : 0) - (f_rd_ok ? 1 : 0);
    end
  end

  assign f_empty = (f_cnt == 0);
  assign f_locs  = 5'(f_cnt);

  // Beat collector and monitors, sampled on the falling edge.
  logic [31:0] beat_data [$];
  logic        beat_last [$];
  logic [15:0] beat_ws   [$];
  int          rd_pulses;
  int          busy_cycles;
  int          stab_viol;
  logic        stall_q;
  logic [31:0] stall_data;
  logic        stall_last;

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (f_read) rd_pulses++;
      if (busy) busy_cycles++;
      if (stall_q && !(tvalid && tdata == stall_data && tlast == stall_last)) stab_viol++;
      stall_q    = tvalid && !tready;
      stall_data = tdata;
      stall_last = tlast;
      if (tvalid && tready) begin
        beat_data.push_back(tdata);
        beat_last.push_back(tlast);
        beat_ws.push_back(words_sent);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    beat_data.delete();
    beat_last.delete();
    beat_ws.delete();
    rd_pulses   = 0;
    busy_cycles = 0;
    stab_viol   = 0;
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'(base + i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input bit toggle, input string tag);
    int cyc;
    cyc = 0;
    while (beat_data.size() < n && cyc < budget) begin
      if (toggle) tready = ~tready;
      step();
      cyc++;
    end
    checks++;
    if (beat_data.size() < n) begin
      errors++;
      $display("FAIL %s timeout: beats %0d, required %0d", tag, beat_data.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tready = 1'b1; flush = 1'b0; burst_len = '0; wr_en = 1'b0; wr_data = '0;
    clear_mon();
    step(); step();
    checks++; if (tvalid !== 1'b0)      begin errors++; $display("FAIL reset_tvalid got %b exp 0", tvalid); end
    checks++; if (tlast !== 1'b0)       begin errors++; $display("FAIL reset_tlast got %b exp 0", tlast); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (words_sent !== 16'd0) begin errors++; $display("FAIL reset_words got %0d exp 0", words_sent); end
    checks++; if (f_read !== 1'b0)      begin errors++; $display("FAIL reset_fifo_read got %b exp 0", f_read); end
    rst = 1'b0;
    step(); step();
  endtask

  task automatic test_burst5();
    clear_mon();
    burst_len = 16'd5; tready = 1'b1;
    push_words(100, 5);
    wait_beats(5, 60, 1'b0, "burst5");
    repeat (5) step();
    checks++; if (beat_data.size() != 5) begin errors++; $display("FAIL burst5_count got %0d exp 5", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 5; i++) begin
      checks++;
      if (beat_data[i] !== 32'(100 + i) || beat_last[i] !== (i == 4)) begin
        errors++;
        $display("FAIL burst5_beat%0d got %0d/%b exp %0d/%b", i, beat_data[i], beat_last[i], 100 + i, (i == 4));
      end
    end
    checks++; if (words_sent !== 16'd0) begin errors++; $display("FAIL burst5_words got %0d exp 0", words_sent); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL burst5_busy got %b exp 0", busy); end
  endtask

  task automatic test_burst4_flush();
    clear_mon();
    burst_len = 16'd4; tready = 1'b1;
    push_words(200, 10);
    wait_beats(9, 80, 1'b0, "b4_nine");
    repeat (6) step();
    checks++; if (beat_data.size() != 9) begin errors++; $display("FAIL b4_held_count got %0d exp 9", beat_data.size()); end
    checks++; if (tvalid !== 1'b0)       begin errors++; $display("FAIL b4_held_tvalid got %b exp 0", tvalid); end
    checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL b4_held_busy got %b exp 1", busy); end
    checks++; if (words_sent !== 16'd1)  begin errors++; $display("FAIL b4_held_words got %0d exp 1", words_sent); end
    pulse_flush();
    wait_beats(10, 20, 1'b0, "b4_flush");
    repeat (3) step();
    for (int i = 0; i < beat_data.size() && i < 10; i++) begin
      checks++;
      if (beat_data[i] !== 32'(200 + i) || beat_last[i] !== (i == 3 || i == 7 || i == 9)) begin
        errors++;
        $display("FAIL b4_beat%0d got %0d/%b exp %0d/%b", i, beat_data[i], beat_last[i], 200 + i,
                 (i == 3 || i == 7 || i == 9));
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b4_flush_busy got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    burst_len = 16'd0; tready = 1'b0;
    push_words(300, 32);
    tready = 1'b1;
    wait_beats(31, 400, 1'b1, "bp_31");
    repeat (4) begin tready = ~tready; step(); end
    checks++; if (beat_data.size() != 31) begin errors++; $display("FAIL bp_held_count got %0d exp 31", beat_data.size()); end
    pulse_flush();
    wait_beats(32, 40, 1'b1, "bp_flush");
    tready = 1'b1;
    repeat (4) step();
    checks++; if (beat_data.size() != 32) begin errors++; $display("FAIL bp_count got %0d exp 32", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 32; i++) begin
      checks++;
      if (beat_data[i] !== 32'(300 + i) || beat_last[i] !== (i == 31)) begin
        errors++;
        $display("FAIL bp_beat%0d got %0d/%b exp %0d/%b", i, beat_data[i], beat_last[i], 300 + i, (i == 31));
      end
    end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stable got %0d exp 0", stab_viol); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL bp_busy got %b exp 0", busy); end
  endtask

  task automatic test_empty_flush();
    clear_mon();
    tready = 1'b1;
    pulse_flush();
    repeat (5) step();
    checks++; if (beat_data.size() != 0) begin errors++; $display("FAIL ef_beats got %0d exp 0", beat_data.size()); end
    checks++; if (rd_pulses != 0)        begin errors++; $display("FAIL ef_reads got %0d exp 0", rd_pulses); end
    checks++; if (busy_cycles > 2 || busy_cycles < 1) begin
      errors++; $display("FAIL ef_busy_cycles got %0d exp 1..2", busy_cycles);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ef_busy got %b exp 0", busy); end
  endtask

  task automatic test_single_word();
    clear_mon();
    burst_len = 16'd0; tready = 1'b1;
    push_words(400, 1);
    repeat (10) step();
    checks++; if (rd_pulses != 1)        begin errors++; $display("FAIL sw_reads got %0d exp 1", rd_pulses); end
    checks++; if (beat_data.size() != 0) begin errors++; $display("FAIL sw_held got %0d beats exp 0", beat_data.size()); end
    checks++; if (tvalid !== 1'b0)       begin errors++; $display("FAIL sw_tvalid got %b exp 0", tvalid); end
    pulse_flush();
    wait_beats(1, 20, 1'b0, "sw_flush");
    repeat (3) step();
    checks++;
    if (beat_data.size() != 1 || beat_data[0] !== 32'd400 || beat_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL sw_beat got n=%0d d=%0d l=%b exp n=1 d=400 l=1", beat_data.size(),
               (beat_data.size() > 0) ? beat_data[0] : 32'd0, (beat_data.size() > 0) ? beat_last[0] : 1'b0);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_packet();
    clear_mon();
    burst_len = 16'd4; tready = 1'b0;
    push_words(600, 8);
    tready = 1'b1;
    wait_beats(2, 20, 1'b0, "rm_two");
    step();
    rst = 1'b1;
    #1;
    checks++; if (tvalid !== 1'b0)      begin errors++; $display("FAIL rm_tvalid got %b exp 0", tvalid); end
    checks++; if (tlast !== 1'b0)       begin errors++; $display("FAIL rm_tlast got %b exp 0", tlast); end
    checks++; if (tdata !== 32'd0)      begin errors++; $display("FAIL rm_tdata got %0d exp 0", tdata); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
    checks++; if (words_sent !== 16'd0) begin errors++; $display("FAIL rm_words got %0d exp 0", words_sent); end
    checks++; if (f_read !== 1'b0)      begin errors++; $display("FAIL rm_fifo_read got %b exp 0", f_read); end
    step(); step();
    rst = 1'b0;
    step();
    clear_mon();
    push_words(500, 4);
    wait_beats(4, 40, 1'b0, "rm_restart");
    repeat (3) step();
    checks++; if (beat_data.size() != 4) begin errors++; $display("FAIL rm_count got %0d exp 4", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 4; i++) begin
      checks++;
      if (beat_data[i] !== 32'(500 + i) || beat_last[i] !== (i == 3) || beat_ws[i] !== 16'(i)) begin
        errors++;
        $display("FAIL rm_beat%0d got %0d/%b/ws%0d exp %0d/%b/ws%0d", i, beat_data[i], beat_last[i],
                 beat_ws[i], 500 + i, (i == 3), i);
      end
    end
    checks++; if (words_sent !== 16'd0) begin errors++; $display("FAIL rm_words_end got %0d exp 0", words_sent); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_burst5();
    test_burst4_flush();
    test_backpressure();
    test_empty_flush();
    test_single_word();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
